// File: rtl/mm_stream_host.sv
// mm_stream_host: sequences one accelerator job (configure over AXI-lite,
// stream 32 input words out, collect 16 result words, poll ap_done).
module mm_stream_host #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_start,
  output logic                   done,
  input  logic                   ld_we,
  input  logic [4:0]             ld_addr,
  input  logic [pDATA_WIDTH-1:0] ld_data,
  input  logic [3:0]             rd_addr,
  output logic [pDATA_WIDTH-1:0] rd_data,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   ss_tvalid,
  input  logic                   ss_tready,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   sm_tvalid,
  output logic                   sm_tready,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast
);
  typedef enum logic [2:0] {IDLE, CFG, STREAM, POLL_AR, POLL_R, DONE} state_t;
  state_t                 state_q, state_d;
  logic [5:0]             tx_cnt_q, tx_cnt_d, tx_nxt;
  logic [4:0]             rx_cnt_q, rx_cnt_d, rx_nxt;
  logic                   aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
  logic                   start, aw_hs, w_hs, ss_hs, sm_hs;
  logic [pDATA_WIDTH-1:0] inbuf_q [32];
  logic [pDATA_WIDTH-1:0] resbuf_q [16];
  logic                   unused_ok;
  // Only rdata[1] (ap_done) matters; tlast is informational.
  assign unused_ok = ^{sm_tlast, rdata[pDATA_WIDTH-1:2], rdata[0]};
  assign start = state_q == IDLE && cmd_start;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ss_hs = ss_tvalid && ss_tready;
  assign sm_hs = sm_tvalid && sm_tready;
  assign tx_nxt = tx_cnt_q + {5'd0, ss_hs};
  assign rx_nxt = rx_cnt_q + {4'd0, sm_hs};
  assign rd_data = resbuf_q[rd_addr];
  // State, counters and handshake-complete flags
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      aw_ok_q  <= 1'b0;
      w_ok_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      aw_ok_q  <= aw_ok_d;
      w_ok_q   <= w_ok_d;
    end
  end
  // Next state; CFG and STREAM exits count a handshake landing this cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_start ? CFG : IDLE;
      CFG:     state_d = (aw_ok_q || aw_hs) && (w_ok_q || w_hs) ? STREAM : CFG;
      STREAM:  state_d = tx_nxt == 6'd32 && rx_nxt == 5'd16 ? POLL_AR : STREAM;
      POLL_AR: state_d = arready ? POLL_R : POLL_AR;
      POLL_R:  state_d = rvalid ? (rdata[1] ? DONE : POLL_AR) : POLL_R;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Counters and flags clear only when a job is launched
  always_comb begin
    tx_cnt_d = start ? '0 : tx_nxt;
    rx_cnt_d = start ? '0 : rx_nxt;
    aw_ok_d  = start ? 1'b0 : aw_ok_q || aw_hs;
    w_ok_d   = start ? 1'b0 : w_ok_q || w_hs;
  end
  // Outputs decoded from state; stream data follows tx_cnt so it holds while stalled
  always_comb begin
    awvalid   = state_q == CFG && !aw_ok_q;
    wvalid    = state_q == CFG && !w_ok_q;
    awaddr    = '0;
    wdata     = {{(pDATA_WIDTH-1){1'b0}}, state_q == CFG};
    arvalid   = state_q == POLL_AR;
    araddr    = '0;
    rready    = state_q == POLL_R;
    ss_tvalid = state_q == STREAM && !tx_cnt_q[5];
    ss_tdata  = ss_tvalid ? inbuf_q[tx_cnt_q[4:0]] : '0;
    ss_tlast  = ss_tvalid && tx_cnt_q == 6'd31;
    sm_tready = state_q == STREAM && !rx_cnt_q[4];
    done      = state_q == DONE;
  end
  // Buffers carry no reset so results survive across jobs and resets
  always_ff @(posedge axis_clk) begin
    if (ld_we && state_q == IDLE) inbuf_q[ld_addr] <= ld_data;
    if (sm_hs) resbuf_q[rx_cnt_q[3:0]] <= sm_tdata;
  end
endmodule

// File: tb/tb_mm_stream_host.sv
// tb_mm_stream_host: randomized jobs against bus/accelerator models with a per-cycle checker.
module tb_mm_stream_host;
  logic        clk = 0, rst_n = 0;
  logic        cmd_start = 0, done, ld_we = 0;
  logic [4:0]  ld_addr = 0;
  logic [31:0] ld_data = 0, rd_data, wdata, rdata = 0, ss_tdata, sm_tdata = 0;
  logic [3:0]  rd_addr = 0;
  logic        awvalid, awready = 0, wvalid, wready = 0, arvalid, arready = 0;
  logic        rready, rvalid = 0, ss_tvalid, ss_tready = 0, ss_tlast;
  logic        sm_tvalid = 0, sm_tready, sm_tlast = 0;
  logic [11:0] awaddr, araddr;

  always #5 clk = ~clk;

  mm_stream_host dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .cmd_start(cmd_start), .done(done),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .arvalid(arvalid), .arready(arready), .araddr(araddr), .rready(rready),
    .rvalid(rvalid), .rdata(rdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready),
    .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready),
    .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  int n_cmp = 0, n_err = 0;
  logic [31:0] m_in [32];
  logic [31:0] in_w [32];
  logic [31:0] exp_res [$];
  logic [31:0] out_q [$];
  logic [31:0] acc_c, prev_data;
  int beats, res_cnt, aw_hs, w_hs, ar_hs, polls, done_cnt, aw_cyc, w_cyc;
  int aw_delay = 0, w_delay = 0, busy_polls = 0, ss_mode = 0, sm_rand = 0, ar_rand = 0, acc_prod = 1;
  int aw_seen, w_seen, r_wait;
  bit hold = 1, r_pend, r_acc, sm_acc, prev_stall, tog;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus slave, accelerator and per-cycle checker: drive at negedge, observe handshakes 1ns later
  initial forever begin
    @(negedge clk);
    if (hold) begin
      awready = 0; wready = 0; arready = 0; rvalid = 0; ss_tready = 0;
      sm_tvalid = 0; sm_tdata = 0; sm_tlast = 0; out_q.delete();
      r_pend = 0; r_acc = 0; sm_acc = 0; aw_seen = 0; w_seen = 0; prev_stall = 0;
    end else begin
      awready = awvalid && aw_seen >= aw_delay;
      wready  = wvalid && w_seen >= w_delay;
      arready = arvalid && (ar_rand == 0 || $urandom_range(1, 0) == 1);
      if (r_acc) begin rvalid = 0; r_acc = 0; end
      if (r_pend && !rvalid) begin
        if (r_wait == 0) begin
          rvalid = 1;
          rdata  = ($urandom & 32'hFFFF_FFFD) | (polls >= busy_polls ? 32'h2 : 32'h0);
          r_pend = 0;
        end else r_wait--;
      end
      tog = !tog;
      ss_tready = ss_mode == 0 ? 1'b1 : ss_mode == 1 ? tog : 1'($urandom_range(1, 0));
      if (sm_acc) begin sm_tvalid = 0; sm_acc = 0; end
      if (!sm_tvalid && out_q.size() > 0 && (sm_rand == 0 || $urandom_range(2, 0) != 0)) begin
        sm_tvalid = 1;
        sm_tdata  = out_q.pop_front();
        sm_tlast  = out_q.size() == 0;
      end
    end
    #1;
    if (!hold) begin
      if (awvalid) begin
        aw_cyc++;
        if (awready) begin aw_hs++; aw_seen = 0; chk("awaddr", awaddr, 0); end else aw_seen++;
      end
      if (wvalid) begin
        w_cyc++;
        if (wready) begin w_hs++; w_seen = 0; chk("wdata", wdata, 1); end else w_seen++;
      end
      if (arvalid && arready) begin
        ar_hs++; r_pend = 1; r_wait = $urandom_range(2, 0);
        chk("araddr", araddr, 0);
      end
      if (rvalid && rready) begin polls++; r_acc = 1; end
      if (prev_stall) begin
        chk("ss_hold_valid", ss_tvalid, 1);
        chk("ss_hold_data", ss_tdata, prev_data);
      end
      chk("tlast_without_valid", ss_tlast & ~ss_tvalid, 0);
      if (ss_tvalid && ss_tready && beats < 32) begin
        chk("ss_tdata", ss_tdata, m_in[beats]);
        chk("ss_tlast", ss_tlast, beats == 31);
        in_w[beats] = ss_tdata;
        if (beats == 31 && acc_prod != 0)
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
              acc_c = 0;
              for (int k = 0; k < 4; k++) acc_c += in_w[i*4+k] * in_w[16+k*4+j];
              out_q.push_back(acc_c);
            end
      end
      if (ss_tvalid && ss_tready) beats++;
      prev_stall = ss_tvalid && !ss_tready;
      prev_data  = ss_tdata;
      if (sm_tvalid && sm_tready) begin exp_res.push_back(sm_tdata); res_cnt++; sm_acc = 1; end
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string name);
    chk({name, "_ctrl"}, {awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, sm_tready, done}, 0);
    chk({name, "_data"}, {awaddr, araddr, wdata, ss_tdata}, 0);
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ld_we = 1; ld_addr = 5'(i);
      ld_data = mode == 1 ? 32'(i < 16 ? i + 1 : i - 14) : $urandom;
      m_in[i] = ld_data;
    end
    @(negedge clk) ld_we = 0;
  endtask

  task automatic start_job();
    beats = 0; res_cnt = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; polls = 0;
    done_cnt = 0; aw_cyc = 0; w_cyc = 0; prev_stall = 0;
    exp_res.delete();
    if (acc_prod == 0) for (int i = 0; i < 16; i++) out_q.push_back($urandom);
    @(negedge clk) cmd_start = 1;
    @(negedge clk) cmd_start = 0;
  endtask

  task automatic finish_job(input string nm);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
    chk({nm, "_done_seen"}, done_cnt > 0, 1);
    tick(3);
    chk({nm, "_beats"}, beats, 32);
    chk({nm, "_results"}, res_cnt, 16);
    chk({nm, "_aw_hs"}, aw_hs, 1);
    chk({nm, "_w_hs"}, w_hs, 1);
    chk({nm, "_ar_hs"}, ar_hs, busy_polls + 1);
    chk({nm, "_polls"}, polls, busy_polls + 1);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) rd_addr = 4'(i);
      #1 chk({nm, "_resbuf"}, rd_data, i < exp_res.size() ? exp_res[i] : 32'hBAD0_0000);
    end
  endtask

  task automatic setup(input int awd, wd, bp, ssm, smr, arr, prod);
    aw_delay = awd; w_delay = wd; busy_polls = bp; ss_mode = ssm;
    sm_rand = smr; ar_rand = arr; acc_prod = prod;
  endtask

  initial begin
    int t;
    tick(2);
    check_reset_outs("reset");
    rst_n = 1; hold = 0;
    tick(2);

    setup(0, 0, 0, 0, 0, 0, 1);
    load(1);
    start_job();
    finish_job("basic");
    chk("pin_model_c00", exp_res.size() > 0 ? exp_res[0] : 0, 100);
    @(negedge clk) rd_addr = 0;
    #1 chk("pin_resbuf0", rd_data, 100);
    @(negedge clk) rd_addr = 15;
    #1 chk("pin_resbuf15", rd_data, 658);

    setup(3, 0, 2, 1, 1, 0, 0);
    load(2);
    start_job();
    finish_job("aw_late");
    chk("aw_valid_cycles", aw_cyc, 4);
    chk("w_valid_cycles", w_cyc, 1);

    setup(1, 2, 1, 2, 1, 1, 0);
    load(2);
    start_job();
    t = 0;
    while (!ss_tvalid && t < 500) begin @(negedge clk); t++; end
    chk("inj_reach_stream", ss_tvalid, 1);
    cmd_start = 1;
    @(negedge clk) cmd_start = 0;
    t = 0;
    while (!rready && t < 2000) begin @(negedge clk); t++; end
    chk("inj_reach_poll_r", rready, 1);
    ld_we = 1; ld_addr = 5; ld_data = ~m_in[5];
    @(negedge clk) ld_we = 0;
    finish_job("inject");

    setup(0, 0, 0, 2, 1, 1, 1);
    start_job();
    finish_job("reuse_inbuf");

    setup(0, 0, 0, 2, 1, 0, 0);
    start_job();
    t = 0;
    while (beats < 10 && t < 1000) begin @(negedge clk); t++; end
    chk("rst_reach_beat10", beats, 10);
    rst_n = 0; hold = 1;
    #1 check_reset_outs("midjob_async");
    @(posedge clk);
    #1 check_reset_outs("midjob_edge");
    tick(2);
    rst_n = 1; hold = 0;
    tick(2);
    setup(0, 0, 1, 1, 1, 1, 0);
    start_job();
    finish_job("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mm_stream_host.md
MM_STREAM_HOST -- requirements
Module: mm_stream_host
Interface
REQ-001 pADDR_WIDTH, 12, AXI-lite address width.
REQ-002 pDATA_WIDTH, 32, AXI-lite and AXI-Stream data width; buffer word width.
REQ-003 axis_clk  in  1  single clock; all logic rising-edge.
REQ-004 axis_rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_start  in  1  one-cycle pulse; starts a job; ignored unless FSM in IDLE.
REQ-006 done  out  1  high one cycle when accelerator reports ap_done.
REQ-007 ld_we  in  1  input-buffer write enable; honoured only in IDLE.
REQ-008 ld_addr  in  5  input-buffer word index 0..31.
REQ-009 ld_data  in  32  input-buffer write data.
REQ-010 rd_addr  in  4  result-buffer word index 0..15.
REQ-011 rd_data  out  32  result word at rd_addr, combinational read.
REQ-012 awvalid  out  1  AXI-lite write-address valid.
REQ-013 awready  in  1  AXI-lite write-address ready.
REQ-014 awaddr  out  pADDR_WIDTH  AXI-lite write address.
REQ-015 wvalid  out  1  AXI-lite write-data valid.
REQ-016 wready  in  1  AXI-lite write-data ready.
REQ-017 wdata  out  32  AXI-lite write data.
REQ-018 arvalid  out  1  AXI-lite read-address valid.
REQ-019 arready  in  1  AXI-lite read-address ready.
REQ-020 araddr  out  pADDR_WIDTH  AXI-lite read address.
REQ-021 rready  out  1  AXI-lite read-data ready.
REQ-022 rvalid  in  1  AXI-lite read-data valid.
REQ-023 rdata  in  32  AXI-lite read data.
REQ-024 ss_tvalid  out  1  AXI-Stream master valid toward accelerator.
REQ-025 ss_tready  in  1  AXI-Stream accelerator ready.
REQ-026 ss_tdata  out  32  AXI-Stream master data.
REQ-027 ss_tlast  out  1  high with word 31 only.
REQ-028 sm_tvalid  in  1  AXI-Stream result valid from accelerator.
REQ-029 sm_tready  out  1  AXI-Stream result ready.
REQ-030 sm_tdata  in  32  AXI-Stream result data.
REQ-031 sm_tlast  in  1  result last flag; informational, not used for termination.
Function
REQ-032 FSM states IDLE, CFG, STREAM, POLL_AR, POLL_R, DONE; IDLE->CFG on cmd_start; DONE->IDLE unconditionally next cycle.
REQ-033 CFG: awvalid=wvalid=1, awaddr=0x000, wdata=0x0000_0001; each channel drops independently after its ready is sampled high; exit to STREAM once both handshakes are complete, in either order or in the same cycle.
REQ-034 STREAM: ss_tvalid=1 with ss_tdata=inbuf[tx_cnt]; tx_cnt (0..32) increments on ss_tvalid&&ss_tready; ss_tdata is held stable while ss_tready=0; ss_tvalid=0 after word 31 accepted.
REQ-035 STREAM: sm_tready=1 while rx_cnt<16; on sm_tvalid&&sm_tready, resbuf[rx_cnt]<=sm_tdata and rx_cnt increments; a result accepted in the same cycle as an input word is counted for both.
REQ-036 STREAM->POLL_AR when tx_cnt==32 and rx_cnt==16, both counted including a final beat in the current cycle.
REQ-037 POLL_AR: arvalid=1, araddr=0x000, until arready sampled high, then POLL_R; POLL_R: rready=1; on rvalid, go to DONE if rdata[1]==1, else back to POLL_AR.
REQ-038 done=1 only in DONE; cmd_start during any non-IDLE state is dropped; ld_we outside IDLE is ignored.
REQ-039 rd_data is valid at any time; resbuf contents persist across jobs until overwritten.
REQ-040 Counters wrap only by reset to 0 on IDLE->CFG; no counter exceeds its terminal value.
Reset
REQ-041 axis_rst_n low, at any time including mid-job: FSM=IDLE, tx_cnt=rx_cnt=0, and awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, sm_tready, done all 0; awaddr, araddr, wdata, ss_tdata 0; buffers not cleared.
Verification
REQ-042 Load inbuf 1..16, 2..17, pulse cmd_start, with mm model ready always high -> 32 stream beats, tlast on beat 31, resbuf matches 4x4 product, done after ap_done read.
REQ-043 awready held low 3 cycles after wready -> wvalid drops after 1 cycle, awvalid held 3 cycles, single write of 0x1 to 0x000.
REQ-044 ss_tready toggled every cycle -> ss_tdata stable during stalls, no duplicated or skipped words.
REQ-045 rdata bit1=0 for first two polls, 1 on third -> three AR handshakes, done pulses exactly once.
REQ-046 Reset asserted during STREAM at tx_cnt=10 -> all outputs 0 next edge; new cmd_start restarts from word 0.
REQ-047 cmd_start pulsed in STREAM and ld_we in POLL_R -> no effect on FSM or inbuf.
